// File: rtl/tristate_halfduplex_port_if.sv
// Host request/response handshake plus the three pad-side signals of the shared line.
interface tristate_halfduplex_port_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_err;
  logic       busy;
  logic       line_out;
  logic       line_oe;
  logic       line_in;

  modport master (
    output tx_data, tx_valid, line_in,
    input  tx_ready, rx_data, rx_valid, rx_err, busy, line_out, line_oe
  );

  modport slave (
    input  tx_data, tx_valid, line_in,
    output tx_ready, rx_data, rx_valid, rx_err, busy, line_out, line_oe
  );
endinterface

// File: rtl/tristate_halfduplex_port.sv
// Half-duplex single-wire endpoint: drive one command frame, turn the line around,
// then receive one response frame from the remote device.
module tristate_halfduplex_port #(
  parameter int CLKS_PER_BIT   = 16,
  parameter int TURN_CYCLES    = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic                        clk,
  input logic                        rst,
  tristate_halfduplex_port_if.slave  bus
);

  localparam int CNT_MAX = (CLKS_PER_BIT > TURN_CYCLES) ? CLKS_PER_BIT : TURN_CYCLES;
  localparam int CW      = $clog2(CNT_MAX);
  localparam int TW      = $clog2(TIMEOUT_CYCLES);

  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] TX_START = 4'd1;
  localparam logic [3:0] TX_DATA  = 4'd2;
  localparam logic [3:0] TX_STOP  = 4'd3;
  localparam logic [3:0] TURN     = 4'd4;
  localparam logic [3:0] RX_WAIT  = 4'd5;
  localparam logic [3:0] RX_START = 4'd6;
  localparam logic [3:0] RX_DATA  = 4'd7;
  localparam logic [3:0] RX_STOP  = 4'd8;

  logic [3:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [TW-1:0] tmo;
  logic [7:0]    tx_shift;
  logic [7:0]    rx_shift;
  logic          sync_p0;
  logic          sync_p1;
  logic          accept;
  logic          bit_end;

  assign accept  = (state == IDLE) && bus.tx_valid;
  assign bit_end = (cnt == CW'(CLKS_PER_BIT - 1));

  // Stage p0/p1: pad value is asynchronous, so it is only used after two flops.
  always_ff @(posedge clk) begin
    sync_p0 <= bus.line_in;
    sync_p1 <= sync_p0;
  end

  always_ff @(posedge clk) begin
    if (accept)
      tx_shift <= bus.tx_data;
    else if (state == TX_DATA && bit_end)
      tx_shift <= tx_shift >> 1;
    if (state == RX_DATA && bit_end)
      rx_shift <= {sync_p1, rx_shift[7:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      tmo          <= '0;
      bus.line_oe  <= 1'b0;
      bus.line_out <= 1'b1;
      bus.tx_ready <= 1'b1;
      bus.busy     <= 1'b0;
      bus.rx_valid <= 1'b0;
      bus.rx_err   <= 1'b0;
      bus.rx_data  <= 8'h00;
    end else begin
      bus.rx_valid <= 1'b0;
      bus.rx_err   <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          state        <= TX_START;
          cnt          <= '0;
          bus.line_oe  <= 1'b1;
          bus.line_out <= 1'b0;
          bus.tx_ready <= 1'b0;
          bus.busy     <= 1'b1;
        end
        TX_START: if (bit_end) begin
          state        <= TX_DATA;
          cnt          <= '0;
          bit_idx      <= '0;
          bus.line_out <= tx_shift[0];
        end else cnt <= cnt + 1'b1;
        TX_DATA: if (bit_end) begin
          cnt     <= '0;
          bit_idx <= bit_idx + 1'b1;
          if (bit_idx == 3'd7) begin
            state        <= TX_STOP;
            bus.line_out <= 1'b1;
          end else bus.line_out <= tx_shift[1];
        end else cnt <= cnt + 1'b1;
        TX_STOP: if (bit_end) begin
          state        <= TURN;
          cnt          <= '0;
          bus.line_oe  <= 1'b0;
          bus.line_out <= 1'b1;
        end else cnt <= cnt + 1'b1;
        TURN: if (cnt == CW'(TURN_CYCLES - 1)) begin
          state <= RX_WAIT;
          cnt   <= '0;
          tmo   <= '0;
        end else cnt <= cnt + 1'b1;
        // tmo is deliberately left running across glitch retries from RX_START.
        RX_WAIT: if (!sync_p1) begin
          state <= RX_START;
          cnt   <= '0;
        end else if (tmo == TW'(TIMEOUT_CYCLES - 1)) begin
          state        <= IDLE;
          bus.rx_err   <= 1'b1;
          bus.tx_ready <= 1'b1;
          bus.busy     <= 1'b0;
        end else tmo <= tmo + 1'b1;
        RX_START: if (cnt == CW'(CLKS_PER_BIT / 2 - 1)) begin
          cnt     <= '0;
          bit_idx <= '0;
          state   <= sync_p1 ? RX_WAIT : RX_DATA;
        end else cnt <= cnt + 1'b1;
        RX_DATA: if (bit_end) begin
          cnt     <= '0;
          bit_idx <= bit_idx + 1'b1;
          if (bit_idx == 3'd7) state <= RX_STOP;
        end else cnt <= cnt + 1'b1;
        RX_STOP: if (bit_end) begin
          if (sync_p1) begin
            bus.rx_data  <= rx_shift;
            bus.rx_valid <= 1'b1;
          end else bus.rx_err <= 1'b1;
          state        <= IDLE;
          cnt          <= '0;
          bus.tx_ready <= 1'b1;
          bus.busy     <= 1'b0;
        end else cnt <= cnt + 1'b1;
        default: begin
          state        <= IDLE;
          cnt          <= '0;
          bus.line_oe  <= 1'b0;
          bus.line_out <= 1'b1;
          bus.tx_ready <= 1'b1;
          bus.busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tristate_halfduplex_port.sv
// Bench for tristate_halfduplex_port: pad model with pull-up, remote responder, frame-level reference.
module tb_tristate_halfduplex_port;
  localparam int CPB  = 16;
  localparam int TURN = 8;
  localparam int TMO  = 1024;

  logic clk = 1'b0;
  logic rst;
  logic remote_val;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   n_valid = 0, n_err = 0, n_both = 0, n_rdybusy = 0, n_rise = 0;
  logic [7:0] last_rx = 8'h00;
  logic prev_oe = 1'b0;
  logic [7:0] exp_rx;

  tristate_halfduplex_port_if bus();

  tristate_halfduplex_port #(
    .CLKS_PER_BIT(CPB), .TURN_CYCLES(TURN), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );

  // Resolved pad: our buffer when enabled, else the remote driver or the pull-up (1).
  assign bus.line_in = bus.line_oe ? bus.line_out : remote_val;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.rx_valid) begin
      n_valid <= n_valid + 1;
      last_rx <= bus.rx_data;
    end
    if (bus.rx_err) n_err <= n_err + 1;
    if (bus.rx_valid && bus.rx_err) n_both <= n_both + 1;
    if (!rst && (bus.tx_ready === bus.busy)) n_rdybusy <= n_rdybusy + 1;
    if (bus.line_oe && !prev_oe) n_rise <= n_rise + 1;
    prev_oe <= bus.line_oe;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic send_cmd(input logic [7:0] d, input bit hold, output int oe_cyc,
                          output logic [9:0] bits, output int turn_oe, output int fall_cyc);
    oe_cyc = 0; bits = '1; turn_oe = 0; fall_cyc = 0;
    bus.tx_data = d;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    if (!hold) bus.tx_valid = 1'b0;
    bus.tx_data = 8'($urandom);
    for (int k = 0; k < 12 * CPB; k++) begin
      if (!bus.line_oe) break;
      if ((oe_cyc % CPB) == CPB / 2 && (oe_cyc / CPB) < 10) bits[oe_cyc / CPB] = bus.line_out;
      oe_cyc++;
      @(negedge clk);
    end
    fall_cyc = cyc;
    bus.tx_valid = 1'b0;
    if (bus.line_oe) turn_oe++;
    for (int k = 0; k < TURN - 1; k++) begin
      @(negedge clk);
      if (bus.line_oe) turn_oe++;
    end
  endtask

  task automatic drive_resp(input logic [7:0] r, input logic stop);
    logic [9:0] fr;
    fr = {stop, r, 1'b0};
    for (int i = 0; i < 10; i++) begin
      remote_val = fr[i];
      repeat (CPB) @(negedge clk);
    end
    remote_val = 1'b1;
  endtask

  task automatic test_reset;
    logic [13:0] got;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    got = {bus.line_oe, bus.line_out, bus.tx_ready, bus.busy, bus.rx_valid, bus.rx_err, bus.rx_data};
    checks++;
    if (got !== {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      errors++; $display("FAIL reset_values: got %b expected %b", got, 14'b01_1000_0000_0000);
    end
    rst = 1'b0;
    @(negedge clk);
    bus.tx_data = 8'hC3;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
    repeat (40) @(negedge clk);
    checks++;
    if (bus.line_oe !== 1'b1) begin
      errors++; $display("FAIL reset_pre_oe: got %b expected 1", bus.line_oe);
    end
    rst = 1'b1;
    @(negedge clk);
    got = {bus.line_oe, bus.line_out, bus.tx_ready, bus.busy, 10'd0};
    checks++;
    if (got !== {1'b0, 1'b1, 1'b1, 1'b0, 10'd0}) begin
      errors++; $display("FAIL reset_mid_tx: got %b expected %b", got, 14'b01_1000_0000_0000);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.line_oe, bus.busy, bus.tx_ready} !== 3'b001) begin
      errors++; $display("FAIL reset_after_release: got %b expected 001", {bus.line_oe, bus.busy, bus.tx_ready});
    end
  endtask

  task automatic transfer_and_check(input string tag, input logic [7:0] cmd, input logic [7:0] resp, input int dly);
    int oe_cyc, turn_oe, fall_cyc, bv, be;
    logic [9:0] bits, exp_bits;
    exp_bits = {1'b1, cmd, 1'b0};
    bv = n_valid; be = n_err;
    send_cmd(cmd, 1'b0, oe_cyc, bits, turn_oe, fall_cyc);
    checks++;
    if (oe_cyc !== 10 * CPB) begin
      errors++; $display("FAIL %s oe_cycles: got %0d expected %0d", tag, oe_cyc, 10 * CPB);
    end
    checks++;
    if (bits !== exp_bits) begin
      errors++; $display("FAIL %s pad_bits: got %b expected %b", tag, bits, exp_bits);
    end
    checks++;
    if (turn_oe !== 0) begin
      errors++; $display("FAIL %s turn_driven: got %0d expected 0", tag, turn_oe);
    end
    repeat (dly) @(negedge clk);
    drive_resp(resp, 1'b1);
    exp_rx = resp;
    repeat (10) @(negedge clk);
    checks++;
    if ((n_valid - bv) !== 1 || (n_err - be) !== 0) begin
      errors++; $display("FAIL %s rx_pulses: got valid %0d err %0d expected 1 0", tag, n_valid - bv, n_err - be);
    end
    checks++;
    if (last_rx !== resp || bus.rx_data !== resp) begin
      errors++; $display("FAIL %s rx_data: got %h expected %h", tag, bus.rx_data, resp);
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.tx_ready !== 1'b1) begin
      errors++; $display("FAIL %s idle_after: got busy %b ready %b expected 0 1", tag, bus.busy, bus.tx_ready);
    end
  endtask

  task automatic test_a5_3c;
    transfer_and_check("a5_3c", 8'hA5, 8'h3C, 3);
  endtask

  task automatic test_random_transfers;
    for (int t = 0; t < 4; t++)
      transfer_and_check("random", 8'($urandom), 8'($urandom), int'($urandom_range(1, 20)));
  endtask

  task automatic test_bad_stop;
    int oe_cyc, turn_oe, fall_cyc, bv, be;
    logic [9:0] bits;
    bv = n_valid; be = n_err;
    send_cmd(8'h42, 1'b0, oe_cyc, bits, turn_oe, fall_cyc);
    repeat (5) @(negedge clk);
    drive_resp(8'h81, 1'b0);
    repeat (10) @(negedge clk);
    checks++;
    if ((n_err - be) !== 1 || (n_valid - bv) !== 0) begin
      errors++; $display("FAIL bad_stop pulses: got err %0d valid %0d expected 1 0", n_err - be, n_valid - bv);
    end
    checks++;
    if (bus.rx_data !== exp_rx) begin
      errors++; $display("FAIL bad_stop rx_data_hold: got %h expected %h", bus.rx_data, exp_rx);
    end
  endtask

  task automatic test_timeout;
    int oe_cyc, turn_oe, fall_cyc, bv, be;
    logic [9:0] bits;
    be = n_err; bv = n_valid;
    send_cmd(8'($urandom), 1'b0, oe_cyc, bits, turn_oe, fall_cyc);
    for (int k = 0; k < TMO + 40; k++) begin
      @(negedge clk);
      if (bus.rx_err) break;
    end
    checks++;
    if ((cyc - fall_cyc) !== TURN + TMO) begin
      errors++; $display("FAIL timeout_latency: got %0d expected %0d", cyc - fall_cyc, TURN + TMO);
    end
    @(negedge clk);
    checks++;
    if (bus.tx_ready !== 1'b1) begin
      errors++; $display("FAIL timeout_ready: got %b expected 1", bus.tx_ready);
    end
    checks++;
    if ((n_err - be) !== 1 || (n_valid - bv) !== 0) begin
      errors++; $display("FAIL timeout_pulses: got err %0d valid %0d expected 1 0", n_err - be, n_valid - bv);
    end
  endtask

  task automatic test_glitch;
    int oe_cyc, turn_oe, fall_cyc, bv, be;
    logic [9:0] bits;
    bv = n_valid; be = n_err;
    send_cmd(8'h17, 1'b0, oe_cyc, bits, turn_oe, fall_cyc);
    repeat (4) @(negedge clk);
    remote_val = 1'b0;
    repeat (3) @(negedge clk);
    remote_val = 1'b1;
    repeat (25) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1 || (n_valid - bv) !== 0 || (n_err - be) !== 0) begin
      errors++; $display("FAIL glitch_ignored: got busy %b valid %0d err %0d expected 1 0 0", bus.busy, n_valid - bv, n_err - be);
    end
    drive_resp(8'hFF, 1'b1);
    exp_rx = 8'hFF;
    repeat (10) @(negedge clk);
    checks++;
    if ((n_valid - bv) !== 1 || bus.rx_data !== 8'hFF || (n_err - be) !== 0) begin
      errors++; $display("FAIL glitch_then_ff: got valid %0d data %h err %0d expected 1 ff 0", n_valid - bv, bus.rx_data, n_err - be);
    end
  endtask

  task automatic test_back_to_back;
    int oe_cyc, turn_oe, fall_cyc, br, bv;
    logic [9:0] bits;
    br = n_rise; bv = n_valid;
    send_cmd(8'h6E, 1'b1, oe_cyc, bits, turn_oe, fall_cyc);
    checks++;
    if (bus.tx_ready !== 1'b0 || oe_cyc !== 10 * CPB) begin
      errors++; $display("FAIL hold_valid_frame: got ready %b oe %0d expected 0 %0d", bus.tx_ready, oe_cyc, 10 * CPB);
    end
    drive_resp(8'h5A, 1'b1);
    exp_rx = 8'h5A;
    repeat (10) @(negedge clk);
    checks++;
    if ((n_rise - br) !== 1 || (n_valid - bv) !== 1 || bus.rx_data !== 8'h5A) begin
      errors++; $display("FAIL hold_valid_single: got frames %0d valid %0d data %h expected 1 1 5a", n_rise - br, n_valid - bv, bus.rx_data);
    end
  endtask

  task automatic test_invariants;
    checks++;
    if (n_both !== 0) begin
      errors++; $display("FAIL valid_and_err_together: got %0d expected 0", n_both);
    end
    checks++;
    if (n_rdybusy !== 0) begin
      errors++; $display("FAIL ready_vs_busy: got %0d expected 0", n_rdybusy);
    end
  endtask

  initial begin
    remote_val   = 1'b1;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    exp_rx       = 8'h00;
    test_reset();
    test_a5_3c();
    test_random_transfers();
    test_bad_stop();
    test_timeout();
    test_glitch();
    test_back_to_back();
    test_invariants();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
